boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_pkg.sv | 17 +
 rtl/run_budget_counter.sv | 37 +++
 rtl/boot_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_boot_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared state encoding and constants for boot_sequencer.
// ST_VERIFY exists only when BOOT_VERIFY_EN is defined.
package boot_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
`ifdef BOOT_VERIFY_EN
    ST_VERIFY = 3'd2,
`endif
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } boot_state_e;

endpackage

// File: rtl/run_budget_counter.sv
// Saturating enabled-cycle counter with terminal detection against a budget.
// last_o flags that the current enabled cycle is the final one (budget 0 = unlimited).
module run_budget_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] budget_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (budget_i != '0) && (count_q == budget_i - W'(1));

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program into instruction memory, then enables the CPU.
// Define BOOT_VERIFY_EN to add a checksum readback (VERIFY) before RUN.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int RUN_CNT_W  = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          start,
  input  logic [$clog2(IMEM_WORDS):0]   prog_len,
  input  logic [RUN_CNT_W-1:0]          run_cycles,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_data,
  input  logic                          halt,
  output logic [63:0]                   imem_addr,
  output logic                          imem_wen,
  output logic [31:0]                   imem_wdata,
`ifdef BOOT_VERIFY_EN
  output logic                          imem_ren,
  input  logic [31:0]                   imem_rdata,
  output logic                          verify_err,
`endif
  output logic                          cpu_enable,
  output logic                          busy,
  output logic                          done,
  output logic [RUN_CNT_W-1:0]          cycles_run
);

  localparam int LW = $clog2(IMEM_WORDS) + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(IMEM_WORDS);

  boot_state_e          state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        word_cnt_q, word_cnt_d;
  logic [RUN_CNT_W-1:0] budget_q, budget_d;
  logic                 cpu_en_q;
  logic                 xfer, run_en, run_last, cnt_clr;

`ifdef BOOT_VERIFY_EN
  logic [31:0]   sum_ld_q, sum_ld_d, sum_rd_q, sum_rd_d;
  logic [LW-1:0] rd_cnt_q, rd_cnt_d, ret_cnt_q, ret_cnt_d;
  logic          ren_q, verr_q, verr_d;
`endif

  run_budget_counter #(.W(RUN_CNT_W)) u_budget (
    .clk      (clk),
    .arst     (arst),
    .clr_i    (cnt_clr),
    .en_i     (run_en),
    .budget_i (budget_q),
    .count_o  (cycles_run),
    .last_o   (run_last)
  );

  assign ld_ready   = (state_q == ST_LOAD) && (word_cnt_q < len_q);
  assign xfer       = ld_valid && ld_ready;
  assign imem_wen   = xfer;
  assign imem_wdata = xfer ? ld_data : 32'h0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign cpu_enable = cpu_en_q;

`ifdef BOOT_VERIFY_EN
  assign imem_ren   = (state_q == ST_VERIFY) && (rd_cnt_q < len_q);
  assign verify_err = verr_q;
`endif

  always_comb begin
    imem_addr = '0;
    if (xfer) begin
      imem_addr = 64'(word_cnt_q) * 64'(WORD_BYTES);
    end
`ifdef BOOT_VERIFY_EN
    else if (imem_ren) begin
      imem_addr = 64'(rd_cnt_q) * 64'(WORD_BYTES);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    budget_d   = budget_q;
    cnt_clr    = 1'b0;
    run_en     = 1'b0;
`ifdef BOOT_VERIFY_EN
    sum_ld_d   = sum_ld_q;
    sum_rd_d   = sum_rd_q;
    rd_cnt_d   = rd_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    verr_d     = verr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
          budget_d   = run_cycles;
          word_cnt_d = '0;
          cnt_clr    = 1'b1;
          state_d    = (prog_len != '0) ? ST_LOAD : ST_RUN;
`ifdef BOOT_VERIFY_EN
          sum_ld_d   = '0;
          sum_rd_d   = '0;
          rd_cnt_d   = '0;
          ret_cnt_d  = '0;
          verr_d     = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + LW'(1);
`ifdef BOOT_VERIFY_EN
          sum_ld_d   = sum_ld_q + ld_data;
          if (word_cnt_q == len_q - LW'(1)) state_d = ST_VERIFY;
`else
          if (word_cnt_q == len_q - LW'(1)) state_d = ST_RUN;
`endif
        end
      end
`ifdef BOOT_VERIFY_EN
      ST_VERIFY: begin
        if (imem_ren) rd_cnt_d = rd_cnt_q + LW'(1);
        // Read data lands one cycle after the request, tracked by ren_q.
        if (ren_q) begin
          ret_cnt_d = ret_cnt_q + LW'(1);
          sum_rd_d  = sum_rd_q + imem_rdata;
          if (ret_cnt_q == len_q - LW'(1)) begin
            if (sum_rd_d == sum_ld_q) begin
              state_d = ST_RUN;
            end else begin
              verr_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
`endif
      ST_RUN: begin
        run_en = 1'b1;
        if (halt || run_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      budget_q   <= '0;
      cpu_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      budget_q   <= budget_d;
      // Registered copy of (state == RUN) keeps the enable glitch-free.
      cpu_en_q   <= (state_d == ST_RUN);
    end
  end

`ifdef BOOT_VERIFY_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sum_ld_q  <= '0;
      sum_rd_q  <= '0;
      rd_cnt_q  <= '0;
      ret_cnt_q <= '0;
      ren_q     <= 1'b0;
      verr_q    <= 1'b0;
    end else begin
      sum_ld_q  <= sum_ld_d;
      sum_rd_q  <= sum_rd_d;
      rd_cnt_q  <= rd_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      ren_q     <= imem_ren;
      verr_q    <= verr_d;
    end
  end
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: driver pushes expected writes and run summaries,
// a negedge monitor pops and compares; define BOOT_VERIFY_EN to exercise readback.
`timescale 1ns/1ps
module tb_boot_sequencer;

  localparam int IW = 8;
  localparam int LW = $clog2(IW) + 1;
  localparam int RW = 16;

  logic          clk, arst, start, ld_valid, ld_ready, halt;
  logic          imem_wen, cpu_enable, busy, done;
  logic [LW-1:0] prog_len;
  logic [RW-1:0] run_cycles, cycles_run;
  logic [31:0]   ld_data, imem_wdata;
  logic [63:0]   imem_addr;
`ifdef BOOT_VERIFY_EN
  logic          imem_ren, verify_err;
  logic [31:0]   imem_rdata;
  logic [31:0]   mem [IW];
  int            corrupt_idx = -1;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct { logic [63:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int run; bit verr; } end_t;
  wr_t  exp_wr_q[$];
  end_t exp_end_q[$];
  wr_t  mw;
  end_t me;
  int   en_cnt = 0;
  bit   prev_done = 0;
  logic [31:0] wv [16];

  boot_sequencer #(.IMEM_WORDS(IW), .RUN_CNT_W(RW)) dut (
    .clk        (clk),
    .arst       (arst),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .halt       (halt),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_wdata (imem_wdata),
`ifdef BOOT_VERIFY_EN
    .imem_ren   (imem_ren),
    .imem_rdata (imem_rdata),
    .verify_err (verify_err),
`endif
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .cycles_run (cycles_run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef BOOT_VERIFY_EN
  // Instruction memory model; one chosen word reads back with a flipped bit.
  always @(posedge clk) begin
    if (imem_wen) mem[imem_addr[4:2]] <= imem_wdata;
    if (imem_ren)
      imem_rdata <= mem[imem_addr[4:2]] ^
                    ((int'(imem_addr[4:2]) == corrupt_idx) ? 32'h0000_0100 : 32'h0);
  end
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (arst) begin
      en_cnt    = 0;
      prev_done = 0;
    end else begin
      if (imem_wen) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h, expected no write", imem_addr);
        end else begin
          mw = exp_wr_q.pop_front();
          chk("wr_addr", imem_addr, mw.addr);
          chk("wr_data", 64'(imem_wdata), 64'(mw.data));
        end
      end
      if (cpu_enable) en_cnt++;
      if (done) begin
        chk("done_single_pulse", 64'(prev_done), 64'(0));
        if (exp_end_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected none");
        end else begin
          me = exp_end_q.pop_front();
          chk("enabled_cycles", 64'(en_cnt), 64'(me.run));
          chk("cycles_run", 64'(cycles_run), 64'(me.run));
          chk("busy_in_done", 64'(busy), 64'(1));
`ifdef BOOT_VERIFY_EN
          chk("verify_err", 64'(verify_err), 64'(me.verr));
`endif
        end
        en_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic do_reset();
    #1 arst = 1'b1;
    exp_wr_q.delete();
    exp_end_q.delete();
    start = 1'b0; halt = 1'b0; ld_valid = 1'b0;
    step();
    step();
    arst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_enable"}, 64'(cpu_enable), 64'(0));
    chk({tag, "_ld_ready"},   64'(ld_ready),   64'(0));
    chk({tag, "_imem_wen"},   64'(imem_wen),   64'(0));
    chk({tag, "_imem_addr"},  imem_addr,       64'(0));
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
    chk({tag, "_busy"},       64'(busy),       64'(0));
    chk({tag, "_done"},       64'(done),       64'(0));
    chk({tag, "_cycles_run"}, 64'(cycles_run), 64'(0));
  endtask

  // One boot/run sequence. vmode: 0 always valid, 1 pattern 1,0,0,1,1, 2 random.
  task automatic run_seq(input int len, input int budget, input int halt_k,
                         input int vmode, input int corrupt, input bit b2b_chk);
    int eff, run_len, i, t, k, n, first_x, last_x, first_en;
    bit verr, fin, last_pending, v;
    bit pat [5];
    pat = '{1, 0, 0, 1, 1};
    eff = (len > IW) ? IW : len;
    for (int j = 0; j < eff; j++) exp_wr_q.push_back('{addr: 64'(j * 4), data: wv[j]});
    if (budget == 0) run_len = halt_k;
    else if (halt_k == 0 || halt_k > budget) run_len = budget;
    else run_len = halt_k;
    verr = 0;
`ifdef BOOT_VERIFY_EN
    corrupt_idx = -1;
    if (corrupt >= 0 && eff > 0) begin
      corrupt_idx = corrupt % eff;
      run_len = 0;
      verr = 1;
    end
`endif
    exp_end_q.push_back('{run: run_len, verr: verr});
    $display("seq len=%0d budget=%0d halt_at=%0d vmode=%0d corrupt=%0d -> writes=%0d run=%0d",
             len, budget, halt_k, vmode, corrupt, eff, run_len);

    prog_len = LW'(len);
    run_cycles = RW'(budget);
    start = 1'b1;
    step();
    start = 1'b0;
    prog_len = LW'($urandom);
    run_cycles = RW'($urandom);
    i = 0; t = 0; k = 0; fin = 0; last_pending = 0;
    first_x = -1; last_x = -1; first_en = -1;
    for (n = 0; n < 400 && !fin; n++) begin
      if (done) begin
        fin = 1;
      end else begin
        if (last_pending) begin
          chk("ld_ready_after_last", 64'(ld_ready), 64'(0));
          last_pending = 0;
        end
        if (cpu_enable) begin
          if (first_en < 0) first_en = n;
          k++;
          halt = (k == halt_k);
        end else begin
          halt = 1'($urandom_range(0, 1));
        end
        if (i < eff) begin
          v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[t % 5] : 1'($urandom_range(0, 1));
          t++;
          ld_valid = v;
          ld_data = wv[i];
          if (v && ld_ready) begin
            if (first_x < 0) first_x = n;
            last_x = n;
            i++;
            if (i == eff) last_pending = 1;
          end
        end else begin
          ld_valid = 1'($urandom_range(0, 1));
          ld_data = $urandom;
        end
        start = ($urandom_range(0, 7) == 0);
        step();
      end
    end
    start = 1'b0; halt = 1'b0; ld_valid = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL seq_timeout: got no done within 400 cycles, expected done");
      do_reset();
    end else begin
      step();
      step();
      chk("cycles_run_hold", 64'(cycles_run), 64'(run_len));
      chk("busy_idle", 64'(busy), 64'(0));
      if (b2b_chk) begin
        chk("b2b_write_span", 64'(last_x - first_x), 64'(eff - 1));
`ifndef BOOT_VERIFY_EN
        chk("enable_after_load", 64'(first_en), 64'(last_x + 1));
`endif
      end
    end
  endtask

  initial begin
    int len, budget, hk, vm, cor;
    arst = 1'b0; start = 1'b0; halt = 1'b0; ld_valid = 1'b0;
    ld_data = '0; prog_len = '0; run_cycles = '0;
    #1 arst = 1'b1;
    #1 check_reset_outputs("init");
    step();
    step();
    arst = 1'b0;
    step();

    // Back-to-back load of three words, then CPU enable.
    wv[0] = 32'h0050_0093; wv[1] = 32'h0060_0113; wv[2] = 32'h0020_81B3;
    run_seq(3, 4, 0, 0, -1, 1);
    // Stalled stream 1,0,0,1,1.
    for (int j = 0; j < 16; j++) wv[j] = $urandom;
    run_seq(3, 2, 0, 1, -1, 0);
    // Budget of 10 with no halt.
    run_seq(2, 10, 0, 0, -1, 0);
    // Unlimited budget, halt on the 7th enabled cycle, no program.
    run_seq(0, 0, 7, 0, -1, 0);
    // Oversized length saturates to the memory depth.
    for (int j = 0; j < 16; j++) wv[j] = $urandom;
    run_seq(12, 3, 0, 2, -1, 0);
    // Halt coinciding with budget exhaustion.
    run_seq(1, 5, 5, 0, -1, 0);
    // Readback with one corrupted word (only corrupts when verify is built in).
    run_seq(4, 5, 0, 0, 2, 0);

    // Reset during the second of four load words, then reload from address 0.
    for (int j = 0; j < 16; j++) wv[j] = $urandom;
    exp_wr_q.push_back('{addr: 64'(0), data: wv[0]});
    prog_len = LW'(4); run_cycles = RW'(5); start = 1'b1;
    step();
    start = 1'b0; ld_valid = 1'b1; ld_data = wv[0];
    step();
    ld_data = wv[1];
    #1 arst = 1'b1;
    #1 check_reset_outputs("rst_load");
    exp_wr_q.delete();
    exp_end_q.delete();
    ld_valid = 1'b0;
    step();
    arst = 1'b0;
    step();
    run_seq(4, 3, 0, 0, -1, 0);

    // Reset mid-RUN.
    prog_len = '0; run_cycles = '0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("run_enable_before_rst", 64'(cpu_enable), 64'(1));
    #1 arst = 1'b1;
    #1 check_reset_outputs("rst_run");
    step();
    arst = 1'b0;
    step();

    for (int s = 0; s < 25; s++) begin
      for (int j = 0; j < 16; j++) wv[j] = $urandom;
      len    = $urandom_range(0, 11);
      budget = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      hk     = (budget == 0) ? $urandom_range(1, 12)
             : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15));
      vm     = $urandom_range(0, 2);
      cor    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      run_seq(len, budget, hk, vm, cor, 0);
    end

    repeat (3) step();
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
    chk("end_queue_drained", 64'(exp_end_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
